hdpldadapt_avmm_rdresp_asm: RTL

//  Read-side consumer of the AVMM read-data async FIFO, in the rd_clk domain.

---
 rtl/hdpldadapt_avmm_rdresp_asm_pkg.sv | 27 ++
 rtl/hdpldadapt_avmm_rdresp_asm_if.sv | 26 ++
 rtl/hdpldadapt_avmm_rdresp_asm_tmr.sv | 35 +++
 rtl/hdpldadapt_avmm_rdresp_asm.sv | 139 +++++++++++++
 4 files changed

// File: rtl/hdpldadapt_avmm_rdresp_asm_pkg.sv
// Shared parameters and FSM encoding for the AVMM read-response assembler.
package hdpldadapt_avmm_pkg;

  localparam int DWIDTH = 2;
  localparam int BEATS  = 2;
  localparam int PEND_W = 3;
  localparam int TMO_W  = 8;

  localparam int BEAT_W = 8 * DWIDTH;
  localparam int RDW    = BEAT_W * BEATS;

  // Beat counter width; a single-beat word still needs a 1-bit counter.
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] RESP    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = IDLE,
    S_COLLECT = COLLECT,
    S_RESP    = RESP
  } state_e;

endpackage

// File: rtl/hdpldadapt_avmm_rdresp_asm_if.sv
// FIFO-pop / AVMM-response bundle between the read-data FIFO side and the assembler.
interface hdpldadapt_avmm_rdresp_asm_if;
  import hdpldadapt_avmm_pkg::*;

  logic              avmm_read_req;
  logic [TMO_W-1:0]  r_tmo_val;
  logic              fifo_rd_empty;
  logic [BEAT_W-1:0] fifo_rd_data;
  logic              fifo_rd_en;
  logic [RDW-1:0]    avmm_readdata;
  logic              avmm_readdatavalid;
  logic              avmm_rd_err;
  logic              err_ovf;
  logic              err_unexp;

  modport slave (
    input  avmm_read_req, r_tmo_val, fifo_rd_empty, fifo_rd_data,
    output fifo_rd_en, avmm_readdata, avmm_readdatavalid, avmm_rd_err, err_ovf, err_unexp
  );

  modport master (
    output avmm_read_req, r_tmo_val, fifo_rd_empty, fifo_rd_data,
    input  fifo_rd_en, avmm_readdata, avmm_readdatavalid, avmm_rd_err, err_ovf, err_unexp
  );

endinterface

// File: rtl/hdpldadapt_avmm_rdresp_asm_tmr.sv
// Idle-cycle timeout counter for the COLLECT phase.
// i_clr restarts the count in the current cycle (a pop, or not collecting);
// o_expire fires on the cycle whose transition to RESP makes the strobe land
// exactly i_tmo_val cycles after the last pop (or after COLLECT was entered).
module hdpldadapt_avmm_rdresp_tmr
  import hdpldadapt_avmm_pkg::*;
(
  input  logic             rd_clk,
  input  logic             rd_srst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [TMO_W-1:0] i_tmo_val,
  output logic             o_expire
);

  logic [TMO_W-1:0] r_cnt;
  logic [TMO_W-1:0] w_base;
  logic [TMO_W:0]   w_elapsed;

  assign w_base    = i_clr ? '0 : r_cnt;
  assign w_elapsed = {1'b0, w_base} + {{TMO_W{1'b0}}, 1'b1};
  assign o_expire  = i_en && !i_clr && (i_tmo_val != '0) && (w_elapsed >= {1'b0, i_tmo_val});

  // Saturating count of cycles since the last restart.
  always_ff @(posedge rd_clk) begin
    if (!rd_srst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (w_base == '1) ? w_base : w_base + 1'b1;
    end else if (i_clr) begin
      r_cnt <= '0;
    end
  end

endmodule

// File: rtl/hdpldadapt_avmm_rdresp_asm.sv
// AVMM read-response assembler: pops beats from the read-data FIFO, packs
// BEATS beats into one readdata word and returns one strobe per pending read.
module hdpldadapt_avmm_rdresp_asm
  import hdpldadapt_avmm_pkg::*;
(
  input logic                         rd_clk,
  input logic                         rd_srst_n,
  hdpldadapt_avmm_rdresp_asm_if.slave avmm
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_nxt;
  logic [BCNT_W-1:0] r_beat_cnt;
  logic [RDW-1:0]    r_word;
  logic              r_tmo_hit;
  logic              r_err_ovf;
  logic              r_err_unexp;

  logic w_pop;
  logic w_collect_pop;
  logic w_last_beat;
  logic w_expire;
  logic w_req_drop;
  logic w_pend_inc;
  logic w_pend_dec;
  logic w_tmr_en;
  logic w_tmr_clr;

  // Pops are blocked during reset so nothing is lost while the block is held.
  assign w_pop         = rd_srst_n && !avmm.fifo_rd_empty && (r_state != S_RESP);
  assign w_collect_pop = w_pop && (r_state == S_COLLECT);
  assign w_last_beat   = w_collect_pop && (r_beat_cnt == BCNT_W'(BEATS - 1));

  // A request at max is only accepted when the RESP decrement frees a slot.
  assign w_req_drop = avmm.avmm_read_req && (r_pend == PEND_MAX) && (r_state != S_RESP);
  assign w_pend_inc = avmm.avmm_read_req && !w_req_drop;
  assign w_pend_dec = (r_state == S_RESP);
  assign w_pend_nxt = r_pend + PEND_W'(w_pend_inc) - PEND_W'(w_pend_dec);

  assign w_tmr_en  = (r_state == S_COLLECT);
  assign w_tmr_clr = !w_tmr_en || w_collect_pop;

  hdpldadapt_avmm_rdresp_tmr u_tmr (
    .rd_clk    (rd_clk),
    .rd_srst_n (rd_srst_n),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .i_tmo_val (avmm.r_tmo_val),
    .o_expire  (w_expire)
  );

  // FSM state register.
  always_ff @(posedge rd_clk) begin
    if (!rd_srst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: collect while reads are pending, respond once per word or timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if ((r_pend != '0) || w_pend_inc) begin
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_last_beat || w_expire) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_state_nxt = (w_pend_nxt != '0) ? S_COLLECT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: pop enable from the current state, response fields only in RESP.
  always_comb begin
    avmm.fifo_rd_en         = w_pop;
    avmm.avmm_readdatavalid = 1'b0;
    avmm.avmm_rd_err        = 1'b0;
    avmm.avmm_readdata      = '0;
    avmm.err_ovf            = r_err_ovf;
    avmm.err_unexp          = r_err_unexp;
    if (r_state == S_RESP) begin
      avmm.avmm_readdatavalid = 1'b1;
      avmm.avmm_rd_err        = r_tmo_hit;
      avmm.avmm_readdata      = r_tmo_hit ? '0 : r_word;
    end
  end

  // Beat assembly: each popped beat lands in its slot; a timeout abandons the word.
  always_ff @(posedge rd_clk) begin
    if (!rd_srst_n) begin
      r_beat_cnt <= '0;
      r_word     <= '0;
      r_tmo_hit  <= 1'b0;
    end else begin
      if (w_collect_pop) begin
        for (int b = 0; b < BEATS; b++) begin
          if (r_beat_cnt == BCNT_W'(b)) begin
            r_word[b*BEAT_W +: BEAT_W] <= avmm.fifo_rd_data;
          end
        end
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
      end else if (w_expire) begin
        r_beat_cnt <= '0;
      end
      if (r_state == S_COLLECT) begin
        r_tmo_hit <= w_expire;
      end
    end
  end

  // Outstanding-read count and sticky error flags.
  always_ff @(posedge rd_clk) begin
    if (!rd_srst_n) begin
      r_pend      <= '0;
      r_err_ovf   <= 1'b0;
      r_err_unexp <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_req_drop) begin
        r_err_ovf <= 1'b1;
      end
      if (w_pop && (r_state == S_IDLE)) begin
        r_err_unexp <= 1'b1;
      end
    end
  end

endmodule
